// File: rtl/dmem_if.sv
// Request/addr_ok/data_ok bus between the MEM stage (master) and a data-side
// responder (slave).
interface dmem_if;
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cacheable;
    logic        cancel;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [31:0] cnt_cached;
    logic [31:0] cnt_uncached;

    modport master (
        output req, we, addr, wdata, cacheable, cancel,
        input  addr_ok, data_ok, rdata, cnt_cached, cnt_uncached
    );

    modport slave (
        input  req, we, addr, wdata, cacheable, cancel,
        output addr_ok, data_ok, rdata, cnt_cached, cnt_uncached
    );
endinterface

// File: rtl/dmem_responder.sv
// Behavioural data memory answering the MEM-stage handshake with programmable
// address-hold and data-return latencies; stores commit at the handshake edge.
module dmem_responder #(
    parameter int ADDR_W     = 10,
    parameter int ADDR_DELAY = 0,
    parameter int DATA_DELAY = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] AD_C  = 4'(ADDR_DELAY);
    localparam logic [3:0] DD_C  = 4'(DATA_DELAY);

    typedef enum logic {IDLE, DATA} state_t;

    state_t            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [3:0]        del_q, del_d;
    logic              data_ok_q, data_ok_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       pend_q, pend_d;
    logic              load_q, load_d;
    logic [31:0]       cnt_c_q, cnt_c_d;
    logic [31:0]       cnt_u_q, cnt_u_d;
    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       mem_rd;
    logic              hs;
    logic              unused_addr;

    // Upper bits alias and the byte offset is carried by the byte enables.
    assign idx         = bus.addr[ADDR_W+1:2];
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
    assign mem_rd      = mem_q[idx];
    assign hs          = (state_q == IDLE) & bus.req & ~bus.cancel & (hold_q == AD_C);

    assign bus.addr_ok      = hs;
    assign bus.data_ok      = data_ok_q;
    assign bus.rdata        = rdata_q;
    assign bus.cnt_cached   = cnt_c_q;
    assign bus.cnt_uncached = cnt_u_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        del_d     = del_q;
        data_ok_d = 1'b0;
        rdata_d   = rdata_q;
        pend_d    = pend_q;
        load_d    = load_q;
        cnt_c_d   = cnt_c_q;
        cnt_u_d   = cnt_u_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req & ~bus.cancel)
                    hold_d = (hold_q == AD_C) ? hold_q : hold_q + 4'd1;
                else
                    hold_d = 4'd0;
                if (hs) begin
                    hold_d  = 4'd0;
                    pend_d  = mem_rd;
                    load_d  = (bus.we == 4'b0000);
                    del_d   = DD_C - 4'd1;
                    state_d = DATA;
                    if (bus.cacheable) cnt_c_d = cnt_c_q + 32'd1;
                    else               cnt_u_d = cnt_u_q + 32'd1;
                    // The pulse is registered, so a one-cycle latency is decided here.
                    if (DD_C == 4'd1) begin
                        data_ok_d = 1'b1;
                        if (bus.we == 4'b0000) rdata_d = mem_rd;
                    end
                end
            end
            DATA: begin
                hold_d = 4'd0;
                del_d  = (del_q == 4'd0) ? 4'd0 : del_q - 4'd1;
                if (del_q == 4'd0) begin
                    state_d = IDLE;
                end else if (bus.cancel) begin
                    state_d = IDLE;
                    del_d   = 4'd0;
                end else if (del_q == 4'd1) begin
                    data_ok_d = 1'b1;
                    if (load_q) rdata_d = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= 4'd0;
            del_q     <= 4'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
            load_q    <= 1'b0;
            cnt_c_q   <= 32'd0;
            cnt_u_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            del_q     <= del_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            load_q    <= load_d;
            cnt_c_q   <= cnt_c_d;
            cnt_u_q   <= cnt_u_d;
        end
    end

    // Storage is never cleared; a store survives reset and cancel once accepted.
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
        if (hs) begin
            for (int b = 0; b < 4; b++)
                if (bus.we[b]) mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a default-latency instance and a slow (2/3) instance,
// checked against a transaction-level memory and latency model.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    dmem_if if0();
    dmem_if if1();

    logic        req_v  [2];
    logic [3:0]  we_v   [2];
    logic [31:0] addr_v [2];
    logic [31:0] wd_v   [2];
    logic        cach_v [2];
    logic        can_v  [2];
    logic        ao     [2];
    logic        dok    [2];
    logic [31:0] rd_v   [2];
    logic [31:0] cc_v   [2];
    logic [31:0] cu_v   [2];

    assign if0.req = req_v[0];   assign if1.req = req_v[1];
    assign if0.we = we_v[0];     assign if1.we = we_v[1];
    assign if0.addr = addr_v[0]; assign if1.addr = addr_v[1];
    assign if0.wdata = wd_v[0];  assign if1.wdata = wd_v[1];
    assign if0.cacheable = cach_v[0]; assign if1.cacheable = cach_v[1];
    assign if0.cancel = can_v[0]; assign if1.cancel = can_v[1];
    assign ao[0] = if0.addr_ok;  assign ao[1] = if1.addr_ok;
    assign dok[0] = if0.data_ok; assign dok[1] = if1.data_ok;
    assign rd_v[0] = if0.rdata;  assign rd_v[1] = if1.rdata;
    assign cc_v[0] = if0.cnt_cached;   assign cc_v[1] = if1.cnt_cached;
    assign cu_v[0] = if0.cnt_uncached; assign cu_v[1] = if1.cnt_uncached;

    dmem_responder #(.ADDR_W(10), .ADDR_DELAY(0), .DATA_DELAY(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    dmem_responder #(.ADDR_W(10), .ADDR_DELAY(2), .DATA_DELAY(3)) u1 (.clk(clk), .rst(rst), .bus(if1));

    logic [31:0] mmem   [2][1024];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_cc [2];
    logic [31:0] exp_cu [2];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input int d);
        chk("cnt_cached", cc_v[d], exp_cc[d]);
        chk("cnt_uncached", cu_v[d], exp_cu[d]);
    endtask

    // One request on instance d; cancel_at is the DATA-phase cycle to assert cancel (-1: none).
    task automatic txn(input int d, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input logic c, input int cancel_at);
        int ad, dd, idx;
        logic [31:0] ld_val;
        bit delivered;
        ad  = (d == 0) ? 0 : 2;
        dd  = (d == 0) ? 1 : 3;
        idx = int'(a[11:2]);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wd_v[d] = wd; cach_v[d] = c;
        for (int k = 0; k <= ad; k++) begin
            @(negedge clk);
            chk1("addr_ok_latency", ao[d], k == ad);
            chk1("data_ok_idle", dok[d], 1'b0);
            if (k < ad) begin @(posedge clk); #1; end
        end
        ld_val = mmem[d][idx];
        for (int b = 0; b < 4; b++)
            if (w[b]) mmem[d][idx][8*b +: 8] = wd[8*b +: 8];
        if (c) exp_cc[d] = exp_cc[d] + 32'd1;
        else   exp_cu[d] = exp_cu[d] + 32'd1;
        delivered = !(cancel_at >= 1 && cancel_at < dd);
        @(posedge clk); #1;
        req_v[d] = 1'b0; we_v[d] = 4'b0000;
        for (int j = 1; j <= dd; j++) begin
            if (j == cancel_at) can_v[d] = 1'b1;
            @(negedge clk);
            chk1("data_ok_latency", dok[d], (j == dd) && delivered);
            chk1("addr_ok_busy", ao[d], 1'b0);
            if (j == dd && delivered && w == 4'b0000) begin
                chk("load_rdata", rd_v[d], ld_val);
                exp_rd[d] = ld_val;
            end else begin
                chk("rdata_hold", rd_v[d], exp_rd[d]);
            end
            @(posedge clk); #1;
            can_v[d] = 1'b0;
            if (j == cancel_at && !delivered) break;
        end
        chk_cnt(d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base [8];
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; we_v[d] = 4'b0; addr_v[d] = 32'd0; wd_v[d] = 32'd0;
            cach_v[d] = 1'b0; can_v[d] = 1'b0;
            exp_rd[d] = 32'd0; exp_cc[d] = 32'd0; exp_cu[d] = 32'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("rst_addr_ok", ao[d], 1'b0);
            chk1("rst_data_ok", dok[d], 1'b0);
            chk("rst_rdata", rd_v[d], 32'd0);
            chk_cnt(d);
        end
        @(posedge clk); #1;

        // Word store then load, byte merge, aliasing on the default instance
        txn(0, 4'hF, 32'h100, 32'h12345678, 1'b1, -1);
        txn(0, 4'h0, 32'h100, 32'h0, 1'b1, -1);
        chk("word_load", rd_v[0], 32'h12345678);
        txn(0, 4'hF, 32'h200, 32'h11223344, 1'b1, -1);
        txn(0, 4'b0010, 32'h201, 32'hAAAAAAAA, 1'b0, -1);
        txn(0, 4'h0, 32'h200, 32'h0, 1'b1, -1);
        chk("byte_merge", rd_v[0], 32'h1122AA44);
        txn(0, 4'hF, 32'h1000, 32'hDEADBEEF, 1'b0, -1);
        txn(0, 4'h0, 32'h0000, 32'h0, 1'b0, -1);
        chk("alias_load", rd_v[0], 32'hDEADBEEF);

        // Cancel in the request cycle suppresses the handshake
        req_v[0] = 1'b1; we_v[0] = 4'h0; addr_v[0] = 32'h100; can_v[0] = 1'b1; cach_v[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("cancel_req_addr_ok", ao[0], 1'b0);
            chk_cnt(0);
            @(posedge clk); #1;
        end
        req_v[0] = 1'b0; can_v[0] = 1'b0;

        // Address/data delay on the slow instance, then a req dropped before addr_ok
        txn(1, 4'hF, 32'h300, 32'hCAFEF00D, 1'b1, -1);
        req_v[1] = 1'b1; we_v[1] = 4'h0; addr_v[1] = 32'h300;
        @(negedge clk); chk1("drop_addr_ok_c0", ao[1], 1'b0);
        @(posedge clk); #1 req_v[1] = 1'b0;
        @(negedge clk); chk1("drop_addr_ok_c1", ao[1], 1'b0);
        @(posedge clk);
        @(negedge clk); chk1("drop_addr_ok_c2", ao[1], 1'b0);
        @(posedge clk); #1;
        txn(1, 4'h0, 32'h300, 32'h0, 1'b1, -1);

        // Cancel during DATA: load suppressed, next request accepted, store survives
        txn(1, 4'hF, 32'h304, 32'h55667788, 1'b1, -1);
        txn(1, 4'h0, 32'h304, 32'h0, 1'b0, 1);
        chk("cancel_rdata", rd_v[1], 32'hCAFEF00D);
        txn(1, 4'h0, 32'h304, 32'h0, 1'b0, -1);
        txn(1, 4'hF, 32'h308, 32'h0BADC0DE, 1'b1, 2);
        txn(1, 4'h0, 32'h308, 32'h0, 1'b1, -1);
        chk("cancel_store_kept", rd_v[1], 32'h0BADC0DE);

        // Reset in the DATA phase aborts the load
        req_v[1] = 1'b1; we_v[1] = 4'h0; addr_v[1] = 32'h300;
        repeat (2) begin @(posedge clk); end
        @(negedge clk); chk1("rst_txn_addr_ok", ao[1], 1'b1);
        @(posedge clk); #1;
        req_v[1] = 1'b0; rst = 1'b1;
        @(negedge clk); chk1("rst_txn_data_ok_a", dok[1], 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = 32'd0; exp_cc[d] = 32'd0; exp_cu[d] = 32'd0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("rst_mid_data_ok", dok[d], 1'b0);
            chk1("rst_mid_addr_ok", ao[d], 1'b0);
            chk("rst_mid_rdata", rd_v[d], 32'd0);
            chk_cnt(d);
        end
        @(posedge clk);
        @(negedge clk); chk1("rst_txn_data_ok_b", dok[1], 1'b0);
        @(posedge clk); #1;

        // Counters: three cacheable, two uncacheable
        for (int i = 0; i < 3; i++) txn(0, 4'h0, 32'h100, 32'h0, 1'b1, -1);
        for (int i = 0; i < 2; i++) txn(0, 4'hF, 32'h200, $urandom, 1'b0, -1);
        chk("cnt_cached_3", cc_v[0], 32'd3);
        chk("cnt_uncached_2", cu_v[0], 32'd2);

        // Randomised traffic over a small preloaded window with aliased upper bits
        for (int i = 0; i < 8; i++) base[i] = 32'h400 + 32'(4 * i);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) txn(d, 4'hF, base[i], $urandom, 1'($urandom), -1);
        for (int i = 0; i < 50; i++) begin
            int d, k, cat;
            logic [3:0] w;
            logic [31:0] a;
            d   = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 7));
            w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a   = ($urandom & 32'hFFFFF000) | base[k] | 32'($urandom_range(0, 3));
            cat = (d == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : -1;
            txn(d, w, a, $urandom, 1'($urandom), cat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
